// File: rtl/dct8_seq_if.sv
// rtl/dct8_seq_if.sv - handshake bundle between the 8-point DCT engine and its neighbours
//
// Purpose: carries the input vector handshake and the serial coefficient
// output handshake of dct8_seq as one port.
// Signals:
//   in_valid  - input vector valid (master -> engine)
//   in_ready  - engine idle, vector will be accepted (engine -> master)
//   in_data   - 8*DATA_W, x0 in the lowest slice, x7 in the top slice
//   out_valid - out_data/out_idx valid (engine -> master)
//   out_ready - downstream accepts the current coefficient (master -> engine)
//   out_data  - OUT_W signed coefficient Y[out_idx]
//   out_idx   - 3-bit coefficient index k
interface dct8_seq_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 24
);
  logic                in_valid;
  logic                in_ready;
  logic [8*DATA_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic [2:0]          out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/dct8_seq.sv
// rtl/dct8_seq.sv - sequential 8-point 1-D DCT-II engine with serial coefficient output
//
// Purpose: accepts one 8-sample vector per handshake, forms the butterfly
// sums/differences, then computes Y0..Y7 one per pass through CALC/OUT and
// streams them out in index order, each tagged with its index.
// Ports:
//   clk - clock, all logic on the rising edge
//   rst - synchronous active-high reset; aborts any block in flight
//   bus - dct8_seq_if.slave: in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_idx
// Parameters: DATA_W (sample width), SIGNED_IN (0 unsigned, 1 two's-complement),
//   OUT_FRAC (fraction bits of Y, 0..15), OUT_W (>= DATA_W+5+OUT_FRAC).
// Build option: define DCT8_SEQ_ROUND_EN for round-half-up; otherwise the
//   scaled result is truncated toward minus infinity.
module dct8_seq #(
  parameter int DATA_W    = 8,
  parameter int SIGNED_IN = 0,
  parameter int OUT_FRAC  = 7,
  parameter int OUT_W     = 24
) (
  input  logic      clk,
  input  logic      rst,
  dct8_seq_if.slave bus
);

  // Butterfly terms need two bits above the sample: one for the sign of an
  // unsigned sample, one for the sum/difference.
  localparam int BF_W  = DATA_W + 2;
  // Operand (BF_W) x coefficient (17) -> BF_W+17, four-term sum adds 2,
  // one more bit of headroom for the rounding offset.
  localparam int P_W   = BF_W + 17 + 2 + 1;
  localparam int ACC_W = (OUT_W > P_W) ? OUT_W : P_W;
  localparam int SHIFT = 16 - OUT_FRAC;

  // Q0.16 coefficients, Ck = 0.5*cos(k*pi/16); 17 bits so negation stays in range.
  localparam logic signed [16:0] C1 = 17'sh07D8A;
  localparam logic signed [16:0] C2 = 17'sh07641;
  localparam logic signed [16:0] C3 = 17'sh06A6D;
  localparam logic signed [16:0] C4 = 17'sh05A82;
  localparam logic signed [16:0] C5 = 17'sh0471C;
  localparam logic signed [16:0] C6 = 17'sh030FB;
  localparam logic signed [16:0] C7 = 17'sh018F8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BFLY = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    accept;
  logic                    advance;

  logic [2:0]              k;
  logic [8*DATA_W-1:0]     x_reg;
  logic signed [BF_W-1:0]  xs [8];
  logic signed [BF_W-1:0]  s  [4];
  logic signed [BF_W-1:0]  d  [4];

  logic signed [BF_W-1:0]  opnd [4];
  logic signed [16:0]      coef [4];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;
  logic [OUT_W-1:0]        y_next;

  logic [OUT_W-1:0]        y_reg;
  logic [2:0]              idx_reg;

  // Widen one sample to the butterfly width, honouring the input mode.
  function automatic logic signed [BF_W-1:0] ext(input logic [DATA_W-1:0] v);
    logic msb;
    msb = (SIGNED_IN != 0) ? v[DATA_W-1] : 1'b0;
    return {msb, msb, v};
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = BFLY;
        end
      end
      BFLY: state_next = CALC;
      CALC: state_next = OUT;
      OUT: begin
        if (bus.out_ready) begin
          if (k == 3'd7) begin
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = CALC;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so neither ready nor
  // valid depends combinationally on the opposite side's input.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = y_reg;
  assign bus.out_idx   = idx_reg;

  // ---------------------------------------------------------------- datapath
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      xs[i] = ext(x_reg[i*DATA_W +: DATA_W]);
    end
  end

  // Every coefficient is a four-term dot product: even k uses the sums,
  // odd k the differences. The even-k forms (s0-s3), (s1-s2) are expanded
  // into per-term signed coefficients so one MAC shape serves all eight.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      opnd[i] = k[0] ? d[i] : s[i];
    end
    coef = '{C4, C4, C4, C4};
    case (k)
      3'd1:    coef = '{C1,  C3,  C5,  C7};
      3'd2:    coef = '{C2,  C6, -C6, -C2};
      3'd3:    coef = '{C3, -C7, -C1, -C5};
      3'd4:    coef = '{C4, -C4, -C4,  C4};
      3'd5:    coef = '{C5, -C1,  C7,  C3};
      3'd6:    coef = '{C6, -C2,  C2, -C6};
      3'd7:    coef = '{C7, -C5,  C3, -C1};
      default: coef = '{C4,  C4,  C4,  C4};
    endcase
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + ACC_W'(opnd[i]) * ACC_W'(coef[i]);
    end
`ifdef DCT8_SEQ_ROUND_EN
    rnd = acc + (ACC_W'(1) << (SHIFT - 1));
`else
    rnd = acc;
`endif
    // The sum is bounded well inside OUT_W, so dropping the upper bits after
    // the arithmetic shift loses nothing.
    y_next = OUT_W'(rnd >>> SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg   <= '0;
      k       <= '0;
      y_reg   <= '0;
      idx_reg <= '0;
      for (int i = 0; i < 4; i++) begin
        s[i] <= '0;
        d[i] <= '0;
      end
    end else begin
      if (accept) begin
        x_reg <= bus.in_data;
        k     <= '0;
      end
      if (state == BFLY) begin
        for (int i = 0; i < 4; i++) begin
          s[i] <= xs[i] + xs[7-i];
          d[i] <= xs[i] - xs[7-i];
        end
      end
      if (state == CALC) begin
        y_reg   <= y_next;
        idx_reg <= k;
      end
      if (advance) begin
        k <= k + 3'd1;
      end
    end
  end

endmodule
